// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: shared definitions for the serial ALU slice and its sequencer.
//   - Opcode encodings (OP_AND .. OP_PASSB)
//   - Sequencer state encoding (ST_IDLE, ST_RUN, ST_DONE; 2 bits)
//   - Default slice width
//   - chains_carry(): true for the opcodes whose carry ripples between slices
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int SLICE_DEFAULT = 8;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic chains_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_serial_if.sv
// ---------------------------------------------------------------------------
// alu_seq_serial_if: valid/ready operand bus and result bus of the serial ALU.
//   Operand side : in_valid, in_ready, a, b, cin, s
//   Result side  : out_valid, out_ready, out, cout, g, e
//   master modport = producer/consumer, slave modport = the ALU.
// ---------------------------------------------------------------------------
interface alu_seq_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             g;
  logic             e;

  modport master (
    output in_valid, a, b, cin, s, out_ready,
    input  in_ready, out_valid, out, cout, g, e
  );

  modport slave (
    input  in_valid, a, b, cin, s, out_ready,
    output in_ready, out_valid, out, cout, g, e
  );
endinterface

// File: rtl/alu_slice_comb.sv
// ---------------------------------------------------------------------------
// alu_slice_comb: purely combinational SLICE-wide ALU slice.
//   Inputs : a, b (slice operands), cin (carry in), s (opcode)
//   Outputs: y (slice result), co (carry out, 0 for non-arithmetic ops),
//            g_i (unsigned a>b for this slice), e_i (a==b for this slice)
// ---------------------------------------------------------------------------
module alu_slice_comb
  import alu_pkg::*;
#(
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       s,
  output logic [SLICE-1:0] y,
  output logic             co,
  output logic             g_i,
  output logic             e_i
);

  always_comb begin
    y  = '0;
    co = 1'b0;
    case (s)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_ADD:   {co, y} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
      // SUB is A + ~B + cin; cin=1 yields a true two's-complement subtract.
      OP_SUB:   {co, y} = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
      OP_PASSA: y = a;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

  assign g_i = (a > b);
  assign e_i = (a == b);

endmodule

// File: rtl/alu_seq_serial.sv
// ---------------------------------------------------------------------------
// alu_seq_serial: multi-cycle ALU that reuses one SLICE-wide slice over
// NSLICE = WIDTH/SLICE cycles, least-significant slice first.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : slave side of alu_seq_serial_if (operand and result handshakes)
// Results (out, cout, g, e) are loaded only on entry to DONE and held until
// the next operation completes. WIDTH must match the interface's WIDTH.
// ---------------------------------------------------------------------------
module alu_seq_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_serial_if.slave   bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, shadow_reg, out_reg;
  logic [2:0]       s_reg;
  logic             carry_reg, g_acc_reg, e_acc_reg;
  logic             cout_reg, g_reg, e_reg;
  logic [CW-1:0]    cnt_reg;

  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [WIDTH-1:0] merged;
  logic [SLICE-1:0] y;
  logic             co, g_i, e_i, slice_cin, last, g_new, e_new;

  // Split operands into slices; merged is the shadow result with the
  // current slice's output dropped into its position.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
    assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
    assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
    assign merged[gi*SLICE +: SLICE] =
      (cnt_reg == CW'(gi)) ? y : shadow_reg[gi*SLICE +: SLICE];
  end

  // Carry ripples between slices only for arithmetic ops.
  assign slice_cin = chains_carry(s_reg) ? carry_reg : 1'b0;

  alu_slice_comb #(.SLICE(SLICE)) u_slice (
    .a   (a_sl[cnt_reg]),
    .b   (b_sl[cnt_reg]),
    .cin (slice_cin),
    .s   (s_reg),
    .y   (y),
    .co  (co),
    .g_i (g_i),
    .e_i (e_i)
  );

  assign last  = (cnt_reg == CW'(NSLICE - 1));
  // Higher slices are processed later, so the newest slice compare dominates.
  assign g_new = g_i | (e_i & g_acc_reg);
  assign e_new = e_i & e_acc_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) state_next = ST_RUN;
      ST_RUN:  if (last)         state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_reg == ST_IDLE);
    bus.out_valid = (state_reg == ST_DONE);
  end

  assign bus.out  = out_reg;
  assign bus.cout = cout_reg;
  assign bus.g    = g_reg;
  assign bus.e    = e_reg;

  // Datapath: operand latch, slice sequencing, accumulators, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= '0;
      shadow_reg <= '0;
      out_reg    <= '0;
      carry_reg  <= 1'b0;
      g_acc_reg  <= 1'b0;
      e_acc_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      g_reg      <= 1'b0;
      e_reg      <= 1'b0;
      cnt_reg    <= '0;
    end else if (state_reg == ST_IDLE && bus.in_valid) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      s_reg     <= bus.s;
      carry_reg <= bus.cin;
      g_acc_reg <= 1'b0;
      e_acc_reg <= 1'b1;
      cnt_reg   <= '0;
    end else if (state_reg == ST_RUN) begin
      shadow_reg <= merged;
      carry_reg  <= co;
      g_acc_reg  <= g_new;
      e_acc_reg  <= e_new;
      if (last) begin
        out_reg  <= merged;
        cout_reg <= co;
        g_reg    <= g_new;
        e_reg    <= e_new;
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_serial.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_serial: directed and randomized checks of alu_seq_serial against
// a whole-word arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq_serial;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alu_seq_serial_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_serial #(.WIDTH(WIDTH), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, g, e, out} from whole-word arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic [2:0] s);
    logic [32:0] sum;
    logic [31:0] r;
    logic        co;
    co  = 1'b0;
    sum = '0;
    case (s)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: begin sum = {1'b0, a} + {1'b0, b} + 33'(ci);  r = sum[31:0]; co = sum[32]; end
      3'd5: begin sum = {1'b0, a} + {1'b0, ~b} + 33'(ci); r = sum[31:0]; co = sum[32]; end
      3'd6: r = a;
      default: r = b;
    endcase
    return {co, (a > b), (a == b), r};
  endfunction

  task automatic check_result(input string tag, input logic [34:0] exp);
    check({tag, "/out"},  bus.out,  exp[31:0]);
    check({tag, "/cout"}, 32'(bus.cout), 32'(exp[34]));
    check({tag, "/g"},    32'(bus.g),    32'(exp[33]));
    check({tag, "/e"},    32'(bus.e),    32'(exp[32]));
  endtask

  // Present one op, wait for its result and check it. With rel=1 the result is
  // then consumed (after 'hold' cycles of backpressure) and IDLE is checked.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [2:0] s, input int hold,
                       input bit rel, output logic [34:0] exp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = ci; bus.s = s;
    tick();
    // Scramble inputs after acceptance; the latched op must be unaffected.
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom); bus.s = 3'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check({tag, "/latency"}, 32'(n), 32'd4);
    exp = model(a, b, ci, s);
    check_result(tag, exp);
    if (rel) begin
      repeat (hold) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "/idle_held"}, bus.out, exp[31:0]);
    end
  endtask

  initial begin
    logic [34:0] exp_a, exp_b;
    logic [31:0] ra, rb;
    int n;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.s = '0;
    rst = 1'b1;
    tick(); tick();
    check("reset/in_ready",  32'(bus.in_ready),  32'd1);
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/out",  bus.out, 32'd0);
    check("reset/cout", 32'(bus.cout), 32'd0);
    check("reset/g",    32'(bus.g), 32'd0);
    check("reset/e",    32'(bus.e), 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 3'd4, 0, 1'b1, exp_a);
    do_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd4, 1, 1'b1, exp_a);
    do_op("sub_5_7",    32'h00000005, 32'h00000007, 1'b1, 3'd5, 0, 1'b1, exp_a);
    do_op("and_eq",     32'h12345678, 32'h12345678, 1'b0, 3'd0, 0, 1'b1, exp_a);
    do_op("and_gslice", 32'h00000100, 32'h000000FF, 1'b0, 3'd0, 0, 1'b1, exp_a);
    do_op("nor_cin",    32'hF0F0F0F0, 32'h0F0F0F00, 1'b1, 3'd3, 0, 1'b1, exp_a);

    // Backpressure: result held 10 cycles, second op waits
    do_op("bp_first", 32'hDEADBEEF, 32'h01234567, 1'b1, 3'd4, 0, 1'b0, exp_a);
    bus.in_valid = 1'b1;
    bus.a = 32'h00001234; bus.b = 32'h00001234; bus.cin = 1'b1; bus.s = 3'd5;
    exp_b = model(32'h00001234, 32'h00001234, 1'b1, 3'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp/out_valid", 32'(bus.out_valid), 32'd1);
      check("bp/in_ready",  32'(bus.in_ready),  32'd0);
      check("bp/out",       bus.out, exp_a[31:0]);
    end
    check_result("bp_hold", exp_a);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp/release_idle", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp/second_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("bp_second/latency", 32'(n), 32'd4);
    check_result("bp_second", exp_b);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during RUN cycle 2
    bus.in_valid = 1'b1;
    bus.a = 32'h11111111; bus.b = 32'h22222222; bus.cin = 1'b0; bus.s = 3'd4;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_mid/in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid/out",  bus.out, 32'd0);
    check("rst_mid/cout", 32'(bus.cout), 32'd0);
    check("rst_mid/g",    32'(bus.g), 32'd0);
    check("rst_mid/e",    32'(bus.e), 32'd0);
    tick();
    rst = 1'b0;
    repeat (6) begin
      tick();
      check("rst_mid/no_result", 32'(bus.out_valid), 32'd0);
    end
    do_op("after_rst", 32'h7FFFFFFF, 32'h80000000, 1'b1, 3'd5, 0, 1'b1, exp_a);

    // Randomized ops, with equal and single-byte-differing operand pairs
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 1'b1, exp_a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
